// File: rtl/best_arr_sender_pkg.sv
// Shared geometry and FSM encoding for the best-index array sender.
package best_arr_sender_pkg;
  localparam int DATA_WIDTH = 11;
  localparam int ROW_SIZE   = 26;
  localparam int COL_SIZE   = 19;
  localparam int BLOCKING   = 4;
  localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/best_arr_sender_skid.sv
// Two-entry skid FIFO; head is always held in e0_q so dout is a plain register.
module sender_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d, cnt_after_pop;
  logic             pop_ok;

  always_comb begin
    e0_d          = e0_q;
    e1_d          = e1_q;
    pop_ok        = pop && (cnt_q != 2'd0);
    cnt_after_pop = cnt_q - {1'b0, pop_ok};
    if (pop_ok) e0_d = e1_q;
    // Upstream flow control guarantees a push never lands on a full buffer.
    if (push) begin
      if (cnt_after_pop == 2'd0) e0_d = din;
      else                       e1_d = din;
    end
    cnt_d = cnt_after_pop + {1'b0, push};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = e0_q;
  assign count = cnt_q;
endmodule

// File: rtl/best_arr_sender.sv
// Streams the best-index array in column-blocked order from memory into an
// output FIFO, with a 2-entry skid buffer absorbing the 1-cycle read latency.
module best_arr_sender
  import best_arr_sender_pkg::state_t;
  import best_arr_sender_pkg::IDLE;
  import best_arr_sender_pkg::RUN;
  import best_arr_sender_pkg::DRAIN;
#(
  parameter int DATA_WIDTH = best_arr_sender_pkg::DATA_WIDTH,
  parameter int ROW_SIZE   = best_arr_sender_pkg::ROW_SIZE,
  parameter int COL_SIZE   = best_arr_sender_pkg::COL_SIZE,
  parameter int BLOCKING   = best_arr_sender_pkg::BLOCKING,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_wenq,
  output logic [DATA_WIDTH-1:0] out_wdata,
  input  logic                  out_wfull_n
);
  // One spare bit so block-base + BLOCKING never wraps.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ROW_C    = CW'(ROW_SIZE);
  localparam logic [CW-1:0] COL_LAST = CW'(COL_SIZE - 1);
  localparam logic [CW-1:0] BLK_C    = CW'(BLOCKING);
  localparam logic [CW-1:0] XI_LAST  = CW'(BLOCKING - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] xi_q, xi_d, y_q, y_d;
  logic [CW-1:0] col_base_q, col_base_d, row_base_q, row_base_d;
  logic          inflight_q, inflight_d;

  logic [CW-1:0] col;
  logic          row_end, col_end, blk_last, last_rd, pop, issue_ok;
  logic [1:0]    skid_cnt, occ_sum;

  sender_skid_fifo #(.WIDTH(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (mem_rd_data),
    .pop   (pop),
    .dout  (out_wdata),
    .count (skid_cnt)
  );

  always_comb begin
    col      = col_base_q + xi_q;
    row_end  = (xi_q == XI_LAST) || (col + CW'(1) == ROW_C);
    col_end  = (y_q == COL_LAST);
    blk_last = (col_base_q + BLK_C >= ROW_C);
    last_rd  = row_end && col_end && blk_last;

    pop      = (skid_cnt != 2'd0) && out_wfull_n;
    // Count this cycle's dequeue as free space so the pipe sustains 1 word/cycle.
    occ_sum  = skid_cnt - {1'b0, pop} + {1'b0, inflight_q};
    issue_ok = (occ_sum < 2'd2);

    mem_rd_en   = (state_q == RUN) && issue_ok;
    mem_rd_addr = ADDR_WIDTH'(row_base_q + col);
    out_wenq    = pop;
    done        = (state_q == DRAIN) && pop && (skid_cnt == 2'd1) && !inflight_q;
    busy        = (state_q != IDLE);
  end

  always_comb begin
    state_d    = state_q;
    xi_d       = xi_q;
    y_d        = y_q;
    col_base_d = col_base_q;
    row_base_d = row_base_q;
    inflight_d = mem_rd_en;
    unique case (state_q)
      IDLE: begin
        xi_d       = '0;
        y_d        = '0;
        col_base_d = '0;
        row_base_d = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (mem_rd_en) begin
          if (!row_end) begin
            xi_d = xi_q + CW'(1);
          end else begin
            xi_d = '0;
            if (!col_end) begin
              y_d        = y_q + CW'(1);
              row_base_d = row_base_q + ROW_C;
            end else begin
              y_d        = '0;
              row_base_d = '0;
              col_base_d = col_base_q + BLK_C;
            end
          end
          if (last_rd) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      xi_q       <= '0;
      y_q        <= '0;
      col_base_q <= '0;
      row_base_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      xi_q       <= xi_d;
      y_q        <= y_d;
      col_base_q <= col_base_d;
      row_base_q <= row_base_d;
      inflight_q <= inflight_d;
    end
  end
endmodule

// File: tb/tb_best_arr_sender.sv
// Randomized self-checking bench for best_arr_sender against a blocked-raster order model.
module tb_best_arr_sender;
  import best_arr_sender_pkg::*;
  localparam int AW = $clog2(NUM_QUERYS);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_wfull_n = 1'b1;
  logic [DATA_WIDTH-1:0] mem_rd_data = '0;
  logic busy, done, mem_rd_en, out_wenq;
  logic [AW-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] out_wdata;

  int vec = 0, err = 0, cyc = 0;

  always #5 clk = ~clk;

  best_arr_sender #(
    .DATA_WIDTH(DATA_WIDTH), .ROW_SIZE(ROW_SIZE), .COL_SIZE(COL_SIZE),
    .BLOCKING(BLOCKING), .NUM_QUERYS(NUM_QUERYS), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_wenq(out_wenq), .out_wdata(out_wdata), .out_wfull_n(out_wfull_n)
  );

  // Memory holds data = address, one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= DATA_WIDTH'(mem_rd_addr);
  end

  // Monitor, sampled on the falling edge.
  logic [DATA_WIDTH-1:0] got[$];
  int first_wenq = -1, last_wenq = -1, first_rd = -1;
  int wenq_cnt = 0, done_cnt = 0, done_idx = -1, viol = 0;
  bit mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      got.delete();
      first_wenq <= -1; last_wenq <= -1; first_rd <= -1;
      wenq_cnt <= 0; done_cnt <= 0; done_idx <= -1; viol <= 0;
    end else if (!rst) begin
      if (mem_rd_en && first_rd < 0) first_rd <= cyc;
      if (out_wenq) begin
        if (!out_wfull_n) viol <= viol + 1;
        got.push_back(out_wdata);
        if (first_wenq < 0) first_wenq <= cyc;
        last_wenq <= cyc;
        wenq_cnt <= wenq_cnt + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_idx <= out_wenq ? got.size() - 1 : -1;
      end
    end
  end

  // Reference order: for each column block, every row, every column in the block.
  logic [DATA_WIDTH-1:0] exp_q[$];
  task automatic build_exp();
    exp_q.delete();
    for (int xb = 0; xb * BLOCKING < ROW_SIZE; xb++)
      for (int y = 0; y < COL_SIZE; y++)
        for (int xi = 0; xi < BLOCKING; xi++)
          if (xb * BLOCKING + xi < ROW_SIZE)
            exp_q.push_back(DATA_WIDTH'(y * ROW_SIZE + xb * BLOCKING + xi));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1; tick(); mon_clr = 1'b0; tick();
  endtask

  task automatic pulse_start(output int c);
    c = cyc; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= n) begin to = 1'b0; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    vec++; if (busy !== 1'b0)      begin err++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (done !== 1'b0)      begin err++; $display("FAIL reset_done got %b want 0", done); end
    vec++; if (mem_rd_en !== 1'b0) begin err++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
    vec++; if (out_wenq !== 1'b0)  begin err++; $display("FAIL reset_wenq got %b want 0", out_wenq); end
    vec++; if (mem_rd_addr !== '0) begin err++; $display("FAIL reset_addr got %0d want 0", mem_rd_addr); end
    vec++; if (out_wdata !== '0)   begin err++; $display("FAIL reset_wdata got %0d want 0", out_wdata); end
    rst = 1'b0; tick();
  endtask

  task automatic test_basic();
    int c; bit to;
    int spot_i[9] = '{0, 1, 2, 3, 4, 456, 457, 458, 493};
    int spot_v[9] = '{0, 1, 2, 3, 26, 24, 25, 50, 493};
    clr_mon(); pulse_start(c); wait_done(1, 2000, to); repeat (4) tick();
    vec++; if (to) begin err++; $display("FAIL basic_timeout no done within budget"); end
    vec++; if (got.size() != NUM_QUERYS) begin err++; $display("FAIL basic_count got %0d want %0d", got.size(), NUM_QUERYS); end
    if (got.size() == NUM_QUERYS) begin
      for (int i = 0; i < NUM_QUERYS; i++) begin
        vec++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL basic_word[%0d] got %0d want %0d", i, got[i], exp_q[i]); end
      end
      for (int k = 0; k < 9; k++) begin
        vec++; if (got[spot_i[k]] !== DATA_WIDTH'(spot_v[k])) begin err++; $display("FAIL basic_spot[%0d] got %0d want %0d", spot_i[k], got[spot_i[k]], spot_v[k]); end
      end
    end
    vec++; if (first_rd - c != 1)   begin err++; $display("FAIL basic_rd_latency got %0d want 1", first_rd - c); end
    vec++; if (first_wenq - c != 3) begin err++; $display("FAIL basic_wenq_latency got %0d want 3", first_wenq - c); end
    vec++; if (last_wenq - first_wenq != NUM_QUERYS - 1 || wenq_cnt != NUM_QUERYS)
      begin err++; $display("FAIL basic_continuous span %0d cnt %0d want span %0d", last_wenq - first_wenq + 1, wenq_cnt, NUM_QUERYS); end
    vec++; if (done_cnt != 1)   begin err++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
    vec++; if (done_idx != NUM_QUERYS - 1) begin err++; $display("FAIL basic_done_word got %0d want %0d", done_idx, NUM_QUERYS - 1); end
  endtask

  task automatic test_backpressure();
    int c, lowcnt; bit to;
    lowcnt = 0; to = 1'b1;
    clr_mon(); pulse_start(c);
    for (int i = 0; i < 8000; i++) begin
      if (done_cnt >= 1) begin to = 1'b0; break; end
      if (got.size() >= 100 && lowcnt < 10) begin out_wfull_n = 1'b0; lowcnt++; end
      else if (got.size() >= 100)          out_wfull_n = 1'($urandom_range(0, 1));
      else                                 out_wfull_n = 1'b1;
      tick();
    end
    out_wfull_n = 1'b1; repeat (4) tick();
    vec++; if (to) begin err++; $display("FAIL bp_timeout no done within budget"); end
    vec++; if (got.size() != NUM_QUERYS) begin err++; $display("FAIL bp_count got %0d want %0d", got.size(), NUM_QUERYS); end
    if (got.size() == NUM_QUERYS)
      for (int i = 0; i < NUM_QUERYS; i++) begin
        vec++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL bp_word[%0d] got %0d want %0d", i, got[i], exp_q[i]); end
      end
    vec++; if (viol != 0)       begin err++; $display("FAIL bp_wenq_while_full got %0d want 0", viol); end
    vec++; if (done_cnt != 1)   begin err++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
    vec++; if (done_idx != NUM_QUERYS - 1) begin err++; $display("FAIL bp_done_word got %0d want %0d", done_idx, NUM_QUERYS - 1); end
  endtask

  task automatic test_restart_ignored();
    int c; bit sent, to;
    sent = 1'b0; to = 1'b1;
    clr_mon(); pulse_start(c);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt >= 1) begin to = 1'b0; break; end
      start = (!sent && got.size() >= 200);
      if (start) sent = 1'b1;
      tick();
    end
    start = 1'b0; repeat (40) tick();
    vec++; if (to) begin err++; $display("FAIL restart_timeout no done within budget"); end
    vec++; if (got.size() != NUM_QUERYS) begin err++; $display("FAIL restart_count got %0d want %0d", got.size(), NUM_QUERYS); end
    if (got.size() == NUM_QUERYS)
      for (int i = 0; i < NUM_QUERYS; i++) begin
        vec++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL restart_word[%0d] got %0d want %0d", i, got[i], exp_q[i]); end
      end
    vec++; if (done_cnt != 1) begin err++; $display("FAIL restart_done_cnt got %0d want 1", done_cnt); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL restart_busy_after got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int c; bit to;
    to = 1'b1;
    clr_mon(); pulse_start(c);
    for (int i = 0; i < 2000; i++) begin
      if (got.size() >= 300) begin to = 1'b0; break; end
      tick();
    end
    vec++; if (to) begin err++; $display("FAIL rstmid_timeout word 300 not reached"); end
    rst = 1'b1; #1;
    vec++; if ({busy, done, mem_rd_en, out_wenq} !== 4'b0) begin err++; $display("FAIL rstmid_ctrl got %b want 0000", {busy, done, mem_rd_en, out_wenq}); end
    vec++; if (mem_rd_addr !== '0) begin err++; $display("FAIL rstmid_addr got %0d want 0", mem_rd_addr); end
    vec++; if (out_wdata !== '0)   begin err++; $display("FAIL rstmid_wdata got %0d want 0", out_wdata); end
    repeat (3) tick(); rst = 1'b0; tick();
    clr_mon(); pulse_start(c); wait_done(1, 2000, to); repeat (4) tick();
    vec++; if (to) begin err++; $display("FAIL rstmid_timeout2 no done within budget"); end
    vec++; if (got.size() != NUM_QUERYS) begin err++; $display("FAIL rstmid_count got %0d want %0d", got.size(), NUM_QUERYS); end
    if (got.size() == NUM_QUERYS)
      for (int i = 0; i < NUM_QUERYS; i++) begin
        vec++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL rstmid_word[%0d] got %0d want %0d", i, got[i], exp_q[i]); end
      end
    vec++; if (first_wenq - c != 3) begin err++; $display("FAIL rstmid_latency got %0d want 3", first_wenq - c); end
  endtask

  task automatic test_back_to_back();
    int c; bit to1, to2;
    clr_mon(); pulse_start(c); wait_done(1, 2000, to1);
    pulse_start(c); wait_done(2, 2000, to2); repeat (4) tick();
    vec++; if (to1 || to2) begin err++; $display("FAIL b2b_timeout to1 %b to2 %b want 0 0", to1, to2); end
    vec++; if (got.size() != 2 * NUM_QUERYS) begin err++; $display("FAIL b2b_count got %0d want %0d", got.size(), 2 * NUM_QUERYS); end
    if (got.size() == 2 * NUM_QUERYS)
      for (int i = 0; i < 2 * NUM_QUERYS; i++) begin
        vec++; if (got[i] !== exp_q[i % NUM_QUERYS]) begin err++; $display("FAIL b2b_word[%0d] got %0d want %0d", i, got[i], exp_q[i % NUM_QUERYS]); end
      end
    vec++; if (done_cnt != 2) begin err++; $display("FAIL b2b_done_cnt got %0d want 2", done_cnt); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_exp();
    test_reset();
    test_basic();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/best_arr_sender.md
BEST_ARR_SENDER -- requirements
Module: best_arr_sender

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: DATA_WIDTH, 11, patch-index word width; ROW_SIZE, 26, query columns; COL_SIZE, 19, query rows; BLOCKING, 4, columns per block; NUM_QUERYS, ROW_SIZE*COL_SIZE, total words; ADDR_WIDTH, $clog2(NUM_QUERYS), read address width.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (async active-high reset).
REQ-003 start input 1: single-cycle request to stream the best-index array (driven from send_best_arr).
REQ-004 busy output 1: high from the cycle after start is accepted until done.
REQ-005 done output 1: single-cycle pulse on the cycle the last word is enqueued.
REQ-006 mem_rd_en output 1: read strobe to best-index memory.
REQ-007 mem_rd_addr output ADDR_WIDTH: read address, raster order y*ROW_SIZE+x.
REQ-008 mem_rd_data input DATA_WIDTH: read data, valid exactly 1 cycle after mem_rd_en.
REQ-009 out_wenq output 1: enqueue strobe to output FIFO.
REQ-010 out_wdata output DATA_WIDTH: word enqueued when out_wenq high.
REQ-011 out_wfull_n input 1: output FIFO not full; out_wenq SHALL never be high while it is low.

Function
REQ-012 Emission order SHALL be: outer x-block 0..NBLK-1 (NBLK=ceil(ROW_SIZE/BLOCKING)), then y 0..COL_SIZE-1, then xi 0..BLOCKING-1; address y*ROW_SIZE+x*BLOCKING+xi; words with x*BLOCKING+xi >= ROW_SIZE skipped (defaults: last block xi 0..1 only).
REQ-013 Addresses SHALL be generated by incremental counters/adders only; no multiplier.
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN: IDLE->RUN on start; RUN->DRAIN after the last read issues; DRAIN->IDLE when the final word enqueues (done pulses same cycle).
REQ-015 start while not IDLE SHALL be ignored; start and done coinciding SHALL not restart.
REQ-016 A 2-entry skid FIFO SHALL hold read data; a read issues only when occupancy plus in-flight reads < 2.
REQ-017 out_wenq = skid non-empty AND out_wfull_n; out_wdata = skid head (registered).
REQ-018 Latency: with out_wfull_n high, first mem_rd_en SHALL be in cycle S+1 (S = start-sample cycle), first out_wenq in cycle S+3, then one word per cycle.
REQ-019 Exactly NUM_QUERYS words SHALL be enqueued per start; no loss, duplication, or reorder under any out_wfull_n pattern.
REQ-020 out_wfull_n falling while a read is in flight SHALL land the data in the skid entry; no read issues while skid would overflow.

Reset
REQ-021 rst SHALL asynchronously force IDLE, clear counters and skid, and drive busy, done, mem_rd_en, out_wenq low, mem_rd_addr and out_wdata to 0.
REQ-022 rst mid-transfer SHALL abort; next start restarts at address 0.

Structure
REQ-023 Shared package SHALL hold DATA_WIDTH, ROW_SIZE, COL_SIZE, BLOCKING, NUM_QUERYS, and the FSM state enum.
REQ-024 Skid buffer SHALL be one sub-module, sender_skid_fifo (depth 2, width DATA_WIDTH); rest is flat.

Verification
REQ-025 Memory holds data=addr, out_wfull_n=1, start pulse -> 494 words; words 0..3 = 0..3, word 4 = 26, word 456 = 24, word 457 = 25, word 458 = 50, word 493 = 493; done once, same cycle as word 493.
REQ-026 Same stimulus -> first out_wenq exactly 3 cycles after start sampled; out_wenq continuously high for 494 cycles.
REQ-027 out_wfull_n low for 10 cycles starting at word 100, then random 50% toggling -> identical 494-word sequence; out_wenq never high while out_wfull_n low.
REQ-028 Second start pulse at word 200 -> ignored; total still 494 words, single done.
REQ-029 rst asserted at word 300 -> all outputs 0 within same cycle; new start -> full 494-word sequence from address 0.
REQ-030 Two back-to-back starts after done -> two identical 494-word streams.
